acorn_init_seq: RTL and testbench



---
 rtl/acorn_init_seq_if.sv | 29 ++
 rtl/acorn_init_seq.sv | 105 ++++++++++
 tb/tb_acorn_init_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/acorn_init_seq_if.sv
// acorn_init_seq_if: handshake, key/IV and state-update bus between the init sequencer and its parent
interface acorn_init_seq_if #(
    parameter int STATE_W = 293,
    parameter int KEY_W   = 128,
    parameter int IV_W    = 128
);
    logic               start;
    logic               abort;
    logic [KEY_W-1:0]   key_in;
    logic [IV_W-1:0]    iv_in;
    logic [STATE_W-1:0] state_nxt;
    logic [STATE_W-1:0] state_q;
    logic               m_bit;
    logic               ca;
    logic               cb;
    logic               busy;
    logic               done;
    logic               state_valid;

    modport master (
        output start, abort, key_in, iv_in, state_nxt,
        input  state_q, m_bit, ca, cb, busy, done, state_valid
    );

    modport slave (
        input  start, abort, key_in, iv_in, state_nxt,
        output state_q, m_bit, ca, cb, busy, done, state_valid
    );
endinterface

// File: rtl/acorn_init_seq.sv
// acorn_init_seq: ACORN init sequencer; define ACORN_INIT_ZEROIZE_EN to wipe key/IV after init or abort
module acorn_init_seq #(
    parameter int STATE_W    = 293,
    parameter int KEY_W      = 128,
    parameter int IV_W       = 128,
    parameter int INIT_STEPS = 1792,
    parameter int CNT_W      = 11
) (
    input logic             clk,
    input logic             rst_n,
    acorn_init_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam int KL = $clog2(KEY_W);
    localparam int IL = IV_W > 1 ? $clog2(IV_W) : 1;

    logic [1:0]         fsm;
    logic [CNT_W-1:0]   step;
    logic [KEY_W-1:0]   key_r;
    logic [IV_W-1:0]    iv_r;
    logic [STATE_W-1:0] state_r;
    logic               valid_r;
    logic [IL-1:0]      iv_idx;
    logic               in_run;
    logic               in_iv;
    logic               last;
    logic               msg;
    logic               accept;
    logic               zeroize;

    assign in_run = fsm == RUN;
    assign accept = fsm == IDLE && bus.start && !bus.abort;
    assign last   = step == CNT_W'(INIT_STEPS - 1);
    assign iv_idx = IL'(step - CNT_W'(KEY_W));
    assign in_iv  = step >= CNT_W'(KEY_W) && step < CNT_W'(KEY_W + IV_W);

`ifdef ACORN_INIT_ZEROIZE_EN
    assign zeroize = fsm == FIN || bus.abort;
`else
    assign zeroize = 1'b0;
`endif

    // message schedule: key, then IV, then inverted key[0], then the key repeating
    always_comb begin
        msg = in_iv ? iv_r[iv_idx] : step == CNT_W'(KEY_W + IV_W) ? ~key_r[0] : key_r[step[KL-1:0]];
    end

    assign bus.m_bit       = in_run & msg;
    assign bus.ca          = in_run;
    assign bus.cb          = in_run;
    assign bus.busy        = in_run;
    assign bus.done        = fsm == FIN;
    assign bus.state_q     = state_r;
    assign bus.state_valid = valid_r;

    // key/IV capture on an accepted start, optionally wiped once they are no longer needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r <= '0;
            iv_r  <= '0;
        end else if (zeroize) begin
            key_r <= '0;
            iv_r  <= '0;
        end else if (accept) begin
            key_r <= bus.key_in;
            iv_r  <= bus.iv_in;
        end
    end

    // control FSM and state register; abort beats start, the step counter saturates at the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            step    <= '0;
            state_r <= '0;
            valid_r <= 1'b0;
        end else if (bus.abort) begin
            fsm     <= IDLE;
            step    <= '0;
            state_r <= '0;
            valid_r <= 1'b0;
        end else begin
            case (fsm)
                IDLE: if (bus.start) begin
                    fsm     <= RUN;
                    step    <= '0;
                    state_r <= '0;
                    valid_r <= 1'b0;
                end
                RUN: begin
                    state_r <= bus.state_nxt;
                    step    <= last ? step : step + 1'b1;
                    fsm     <= last ? FIN : RUN;
                end
                FIN: begin
                    valid_r <= 1'b1;
                    fsm     <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acorn_init_seq.sv
// tb_acorn_init_seq: directed table-driven bench for acorn_init_seq with a shift/feedback update stub
module tb_acorn_init_seq;
    localparam int SW = 293;
    localparam int N  = 1792;
    localparam logic [127:0] K1   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] ONES = '1;

    typedef struct { logic [127:0] key; logic [127:0] iv; bit mode; } run_t;
    typedef struct { int step; logic m; } sched_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    bit   mode = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic m_hist [0:N-1];

    acorn_init_seq_if #(.STATE_W(SW), .KEY_W(128), .IV_W(128)) bus ();

    acorn_init_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.state_nxt = {bus.state_q[SW-2:0], bus.m_bit ^ (mode & bus.state_q[SW-1])};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] model(input logic [127:0] k, input logic [127:0] v, input bit md);
        logic [SW-1:0] s;
        logic m;
        s = '0;
        for (int i = 0; i < N; i++) begin
            m = i < 128 ? k[i] : i < 256 ? v[i-128] : i == 256 ? ~k[0] : k[i%128];
            s = {s[SW-2:0], m ^ (md & s[SW-1])};
        end
        return s;
    endfunction

    task automatic do_start(input logic [127:0] k, input logic [127:0] v);
        bus.start = 1'b1;
        bus.key_in = k;
        bus.iv_in = v;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run(input bit poke, output int busy_n, output int cab_n, output int done_n, output int done_at);
        busy_n = 0;
        cab_n = 0;
        done_n = 0;
        done_at = -1;
        for (int c = 0; c < 1900; c++) begin
            bus.start = poke && (c == 5 || c == 1000);
            if (bus.start) begin
                bus.key_in = bus.key_in ^ 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
                bus.iv_in = ~bus.iv_in;
            end
            if (bus.busy) begin
                if (busy_n < N) m_hist[busy_n] = bus.m_bit;
                busy_n++;
            end
            if (bus.ca && bus.cb) cab_n++;
            if (bus.done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            if (done_at >= 0 && !bus.done) break;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic chk_run(input string nm, input logic [127:0] k, input logic [127:0] v, input bit poke);
        int busy_n, cab_n, done_n, done_at;
        run(poke, busy_n, cab_n, done_n, done_at);
        chk({nm, "_busy_cycles"}, SW'(busy_n), SW'(N));
        chk({nm, "_cacb_cycles"}, SW'(cab_n), SW'(N));
        chk({nm, "_done_pulses"}, SW'(done_n), SW'(1));
        chk({nm, "_done_cycle"}, SW'(done_at), SW'(N));
        chk({nm, "_state"}, bus.state_q, model(k, v, mode));
        chk({nm, "_valid"}, SW'(bus.state_valid), SW'(1));
`ifdef ACORN_INIT_ZEROIZE_EN
        chk({nm, "_key_reg"}, SW'(dut.key_r), SW'(0));
        chk({nm, "_iv_reg"}, SW'(dut.iv_r), SW'(0));
`else
        chk({nm, "_key_reg"}, SW'(dut.key_r), SW'(k));
        chk({nm, "_iv_reg"}, SW'(dut.iv_r), SW'(v));
`endif
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_state"}, bus.state_q, '0);
        chk({nm, "_ctl"}, SW'({bus.busy, bus.done, bus.state_valid, bus.m_bit, bus.ca, bus.cb}), SW'(0));
    endtask

    initial begin
        run_t   runs [4];
        sched_t sch [13];
        int     dn;
        runs[0] = '{128'h0, 128'h0, 1'b0};
        runs[1] = '{K1, ONES, 1'b1};
        runs[2] = '{K1, ONES, 1'b0};
        runs[3] = '{128'h8000_0000_0000_0001_DEAD_BEEF_0123_4567, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 1'b1};
        sch[0]  = '{0, 1'b1};
        sch[1]  = '{4, 1'b0};
        sch[2]  = '{8, 1'b0};
        sch[3]  = '{9, 1'b1};
        sch[4]  = '{112, 1'b1};
        sch[5]  = '{127, 1'b0};
        sch[6]  = '{128, 1'b1};
        sch[7]  = '{255, 1'b1};
        sch[8]  = '{256, 1'b0};
        sch[9]  = '{257, 1'b1};
        sch[10] = '{384, 1'b1};
        sch[11] = '{1001, 1'b1};
        sch[12] = '{1791, 1'b0};
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.key_in = '0;
        bus.iv_in = '0;
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_after_reset");
        for (int r = 0; r < 4; r++) begin
            mode = runs[r].mode;
            do_start(runs[r].key, runs[r].iv);
            chk($sformatf("run%0d_start_busy", r), SW'({bus.busy, bus.state_valid}), SW'(2'b10));
            chk_run($sformatf("run%0d", r), runs[r].key, runs[r].iv, 1'b0);
            if (r == 0) chk("run0_state_zero", bus.state_q, '0);
            if (r == 1)
                for (int i = 0; i < 13; i++)
                    chk($sformatf("sched_step%0d", sch[i].step), SW'(m_hist[sch[i].step]), SW'(sch[i].m));
        end
        repeat (3) @(negedge clk);
        chk("valid_holds", SW'(bus.state_valid), SW'(1));
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk_zero("abort_idle");
        mode = 1'b1;
        do_start(K1, ONES);
        repeat (900) @(negedge clk);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk_zero("abort_run");
        dn = 0;
        for (int c = 0; c < 2; c++) begin
            dn += int'(bus.done) + int'(bus.busy);
            @(negedge clk);
        end
        chk("abort_quiet", SW'(dn), SW'(0));
        do_start(128'h0F0F_F0F0_1111_2222_3333_4444_5555_6666, 128'hC3);
        chk_run("after_abort", 128'h0F0F_F0F0_1111_2222_3333_4444_5555_6666, 128'hC3, 1'b0);
        do_start(K1, ONES);
        chk_run("start_pulses", K1, ONES, 1'b1);
        do_start(K1, ONES);
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("after_reset");
        chk("after_reset_key", SW'(dut.key_r), SW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
